// File: rtl/load_ext_unit.sv
// Load unit for the M stage: issues a word-aligned bus read with req/ack,
// then extracts and sign/zero-extends the addressed byte or halfword.
module load_ext_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_type,
    output logic        ld_busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        adel,
    output logic        bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [2:0] LD_LHU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd3;
    localparam logic [2:0] LD_LB  = 3'd4;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        mem_req_reg, mem_req_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [2:0]  type_reg, type_next;
    logic [1:0]  off_reg, off_next;
    logic        rd_valid_reg, rd_valid_next;
    logic [31:0] rd_data_reg, rd_data_next;
    logic        adel_reg, adel_next;
    logic        bus_err_reg, bus_err_next;

    logic        misaligned;
    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    // Little-endian byte lanes of the returned word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = lane[off_reg];
    assign sel_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Types 5..7 fall into the word case together with lw.
    always_comb begin
        case (type_reg)
            LD_LHU:  ext_data = {16'h0000, sel_half};
            LD_LH:   ext_data = {{16{sel_half[15]}}, sel_half};
            LD_LBU:  ext_data = {24'h000000, sel_byte};
            LD_LB:   ext_data = {{24{sel_byte[7]}}, sel_byte};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (ld_type)
            LD_LH, LD_LHU: misaligned = ld_addr[0];
            LD_LB, LD_LBU: misaligned = 1'b0;
            default:       misaligned = |ld_addr[1:0];
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mem_req_next  = mem_req_reg;
        mem_addr_next = mem_addr_reg;
        type_next     = type_reg;
        off_next      = off_reg;
        rd_valid_next = 1'b0;
        rd_data_next  = rd_data_reg;
        adel_next     = 1'b0;
        bus_err_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ld_valid) begin
                    if (misaligned) begin
                        adel_next = 1'b1;
                    end else begin
                        state_next    = WAIT;
                        mem_req_next  = 1'b1;
                        mem_addr_next = {ld_addr[31:2], 2'b00};
                        type_next     = ld_type;
                        off_next      = ld_addr[1:0];
                        cnt_next      = 8'd0;
                    end
                end
            end
            WAIT: begin
                // An ack on the limit cycle still completes the load.
                if (mem_ack) begin
                    rd_valid_next = 1'b1;
                    rd_data_next  = ext_data;
                    state_next    = IDLE;
                    mem_req_next  = 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    bus_err_next = 1'b1;
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    cnt_next     = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 32'h0;
            type_reg     <= 3'd0;
            off_reg      <= 2'd0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= 32'h0;
            adel_reg     <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mem_req_reg  <= mem_req_next;
            mem_addr_reg <= mem_addr_next;
            type_reg     <= type_next;
            off_reg      <= off_next;
            rd_valid_reg <= rd_valid_next;
            rd_data_reg  <= rd_data_next;
            adel_reg     <= adel_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    assign ld_busy  = (state_reg != IDLE);
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign adel     = adel_reg;
    assign bus_err  = bus_err_reg;

endmodule

// File: doc/load_ext_unit.md
Name: load_ext_unit

Overview:
- Read-side counterpart of the store byte-enable logic. Services one load from the M stage at a time.
- Issues a word-aligned read on the data-memory bus using a req/ack handshake, then extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits for W-stage writeback.
- Flags misaligned addresses (AdEL) and bus timeouts.
- Drives a busy signal that the hazard unit uses to stall the pipeline.

Parameters:
- TIMEOUT, default 16: maximum WAIT-state cycles without mem_ack before the load is aborted with bus_err. Range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ld_valid  input  1  load request. Sampled only in IDLE.
- ld_addr  input  32  byte address of the load
- ld_type  input  3  load type: 0 lw, 1 lhu, 2 lh, 3 lbu, 4 lb. Values 5..7 are treated as lw.
- ld_busy  output  1  high whenever state is not IDLE
- mem_req  output  1  read request, held until ack or timeout
- mem_addr  output  32  word address {addr[31:2],2'b00}, registered
- mem_ack  input  1  read data valid on mem_rdata this cycle
- mem_rdata  input  32  read word, little-endian (byte 0 = bits 7:0)
- rd_valid  output  1  one-cycle pulse: rd_data is valid
- rd_data  output  32  extended load result, held until next rd_valid
- adel  output  1  one-cycle pulse: misaligned load, no bus access made
- bus_err  output  1  one-cycle pulse: timeout abort

Behaviour:
- States: IDLE, WAIT.
- Reset, synchronous and active-high, from any state including mid-WAIT:
  - state goes to IDLE; timeout counter clears.
  - mem_req, rd_valid, adel and bus_err go to 0.
  - mem_addr and rd_data go to 32'h0.
  - No rd_valid is produced for an aborted access.
- Alignment check (IDLE, ld_valid=1):
  - lw is misaligned if ld_addr[1:0]!=0.
  - lh/lhu are misaligned if ld_addr[0]!=0.
  - lb/lbu are never misaligned.
- IDLE, ld_valid=1, misaligned: next cycle adel=1 for exactly one cycle. State stays IDLE, mem_req stays 0.
- IDLE, ld_valid=1, aligned: next cycle:
  - state becomes WAIT and mem_req=1;
  - mem_addr is loaded;
  - ld_type and ld_addr[1:0] are latched internally;
  - the counter clears to 0.
- IDLE, ld_valid=0: no action.
- WAIT, mem_ack=1:
  - Capture mem_rdata and apply the extraction rules below.
  - Next cycle: rd_valid=1 with rd_data; state is IDLE; mem_req=0.
  - Latency: rd_valid comes one cycle after ack, and two or more cycles after ld_valid.
- WAIT, mem_ack=0: the counter increments. When the counter reaches TIMEOUT-1 without ack:
  - next cycle bus_err=1 for one cycle;
  - state is IDLE; mem_req=0; rd_data is unchanged.
- mem_ack arriving on the same cycle as the timeout limit: ack wins, and the load completes normally.
- mem_ack while IDLE is ignored.
- ld_valid while not IDLE is ignored. The pipeline must hold its request until ld_busy=0.
- Back-to-back loads: ld_valid sampled in the cycle where rd_valid=1 is accepted, because state is IDLE then.
- Extraction, where off is the latched addr[1:0]:
  - lw: rd_data = word.
  - Halfword: h = word[31:16] if off[1]=1, else word[15:0].
    - lh: sign-extend h.
    - lhu: zero-extend h.
  - Byte: b = word[8*off+7 : 8*off].
    - lb: sign-extend b.
    - lbu: zero-extend b.
- Outputs are registered and glitch-free. rd_valid, adel and bus_err are mutually exclusive.

Test Plan:
1. lw, ld_addr=32'h0000_1004, ack 2 cycles after mem_req rises, mem_rdata=32'hDEAD_BEEF -> mem_addr=32'h0000_1004; rd_valid one cycle after ack; rd_data=32'hDEAD_BEEF; ld_busy high from the cycle after ld_valid until the rd_valid cycle.
2. Word 32'h80FF_1234 at addr 32'h...03:
   - lb -> rd_data=32'hFFFF_FF80.
   - lbu -> rd_data=32'h0000_0080.
   - lb at offset 1 -> rd_data=32'h0000_0012.
3. Word 32'h8001_7FFF:
   - lh at offset 2 -> 32'hFFFF_8001.
   - lhu at offset 2 -> 32'h0000_8001.
   - lh at offset 0 -> 32'h0000_7FFF.
4. Misaligned accesses:
   - lh at 32'h0000_1001 -> adel pulse next cycle, mem_req never asserted, rd_valid=0.
   - lw at 32'h...02 -> adel.
   - lbu at 32'h...03 -> normal access.
5. TIMEOUT=4, mem_ack held 0 -> bus_err pulse after 4 WAIT cycles; mem_req drops; rd_data keeps its previous value. A second run with ack on the 4th WAIT cycle -> rd_valid, no bus_err.
6. Reset asserted during WAIT, then ack arrives -> mem_req=0 the cycle after reset; no rd_valid; a subsequent lw completes normally. Back-to-back: a second ld_valid in the rd_valid cycle -> mem_req reasserts the next cycle.
